// File: rtl/module_millis_alarm_if.sv
// Peripheral bus bundle for the millis alarm unit.
// Master is the core side; slave is the alarm.
interface module_millis_alarm_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  we;
    logic                  re;
    logic [1:0]            addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;

    modport master (
        output we,
        output re,
        output addr,
        output din,
        input  dout
    );

    modport slave (
        input  we,
        input  re,
        input  addr,
        input  din,
        output dout
    );
endinterface

// File: rtl/module_millis_alarm.sv
// Compare/interrupt unit fed by the millisecond timer.
// One-shot or auto-reload alarm with wrap-safe compare.
module module_millis_alarm #(
    parameter int TIMER_WIDTH = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [TIMER_WIDTH-1:0] millis,
    module_millis_alarm_if.slave   bus,
    output logic                   irq
);
    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_CMP    = 2'd1;
    localparam logic [1:0] A_PERIOD = 2'd2;
    localparam logic [1:0] A_MILLIS = 2'd3;

    logic                   en;
    logic                   periodic;
    logic                   pend;
    logic [TIMER_WIDTH-1:0] cmp;
    logic [TIMER_WIDTH-1:0] period;
    logic [TIMER_WIDTH-1:0] diff;
    logic [TIMER_WIDTH-1:0] cmp_step;
    logic                   fire;
    logic                   reload;
    logic                   wr_ctrl;
    logic                   wr_cmp;
    logic                   wr_period;
    logic [DATA_WIDTH-1:0]  rdata;

    // MSB of the modular difference clear means millis is at or past cmp
    assign diff     = millis - cmp;
    assign fire     = en & ~diff[TIMER_WIDTH-1];
    assign reload   = periodic & (period != '0);
    assign cmp_step = cmp + period;

    assign wr_ctrl   = bus.we & (bus.addr == A_CTRL);
    assign wr_cmp    = bus.we & (bus.addr == A_CMP);
    assign wr_period = bus.we & (bus.addr == A_PERIOD);

    always_comb begin
        rdata = '0;
        unique case (bus.addr)
            A_CTRL:   rdata[2:0] = {pend, periodic, en};
            A_CMP:    rdata[TIMER_WIDTH-1:0] = cmp;
            A_PERIOD: rdata[TIMER_WIDTH-1:0] = period;
            A_MILLIS: rdata[TIMER_WIDTH-1:0] = millis;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en       <= 1'b0;
            periodic <= 1'b0;
        end else if (wr_ctrl) begin
            en       <= bus.din[0];
            periodic <= bus.din[1];
        end else if (fire && !reload) begin
            en       <= 1'b0;
        end
    end

    // A fire on the same edge as a software clear keeps the flag set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend <= 1'b0;
        end else if (fire) begin
            pend <= 1'b1;
        end else if (wr_ctrl && bus.din[2]) begin
            pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmp <= '0;
        end else if (wr_cmp) begin
            cmp <= bus.din[TIMER_WIDTH-1:0];
        end else if (fire && reload) begin
            cmp <= cmp_step;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period <= '0;
        end else if (wr_period) begin
            period <= bus.din[TIMER_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.dout <= '0;
        end else if (bus.re) begin
            bus.dout <= rdata;
        end
    end

    assign irq = pend;
endmodule

// File: tb/tb_module_millis_alarm.sv
// Bench for module_millis_alarm: vector table, corner sequences,
// and random traffic against an arithmetic reference model.
module tb_module_millis_alarm;
    localparam int TW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [TW-1:0] millis;
    logic          irq;

    module_millis_alarm_if #(.DATA_WIDTH(DW)) bus ();

    module_millis_alarm #(
        .TIMER_WIDTH(TW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .millis(millis),
        .bus   (bus),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic        m_en;
    logic        m_per;
    logic        m_pend;
    logic [31:0] m_cmp;
    logic [31:0] m_period;
    logic [31:0] m_dout;

    typedef struct {
        logic        we;
        logic        re;
        logic [1:0]  addr;
        logic [31:0] din;
        logic [31:0] ms;
        logic        irq;
        logic [31:0] dout;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        m_en     = 1'b0;
        m_per    = 1'b0;
        m_pend   = 1'b0;
        m_cmp    = '0;
        m_period = '0;
        m_dout   = '0;
    endtask

    // Reference: alarm fires when millis is within half range at/after cmp
    task automatic model_step(input logic w, input logic r,
                              input logic [1:0] a, input logic [31:0] d,
                              input logic [31:0] ms);
        logic [31:0] dlt;
        logic        f;
        logic        n_en;
        logic        n_per;
        logic        n_pend;
        logic [31:0] n_cmp_v;
        logic [31:0] n_period;
        dlt = ms - m_cmp;
        f   = m_en && (dlt < 32'h8000_0000);
        if (r) begin
            case (a)
                2'd0:    m_dout = {29'd0, m_pend, m_per, m_en};
                2'd1:    m_dout = m_cmp;
                2'd2:    m_dout = m_period;
                default: m_dout = ms;
            endcase
        end
        n_en     = m_en;
        n_per    = m_per;
        n_pend   = m_pend;
        n_cmp_v  = m_cmp;
        n_period = m_period;
        if (f) begin
            n_pend = 1'b1;
            if (m_per && m_period != 0) n_cmp_v = m_cmp + m_period;
            else n_en = 1'b0;
        end
        if (w) begin
            case (a)
                2'd0: begin
                    n_en  = d[0];
                    n_per = d[1];
                    if (d[2] && !f) n_pend = 1'b0;
                end
                2'd1:    n_cmp_v  = d;
                2'd2:    n_period = d;
                default: ;
            endcase
        end
        m_en     = n_en;
        m_per    = n_per;
        m_pend   = n_pend;
        m_cmp    = n_cmp_v;
        m_period = n_period;
    endtask

    task automatic cyc(input logic w, input logic r, input logic [1:0] a,
                       input logic [31:0] d, input logic [31:0] ms);
        bus.we   = w;
        bus.re   = r;
        bus.addr = a;
        bus.din  = d;
        millis   = ms;
        @(posedge clk);
        model_step(w, r, a, d, ms);
        #1;
        bus.we = 1'b0;
        bus.re = 1'b0;
        check("irq_model", {31'd0, irq}, {31'd0, m_pend});
        check("dout_model", bus.dout, m_dout);
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        bus.we   = 1'b0;
        bus.re   = 1'b0;
        bus.addr = 2'd0;
        bus.din  = '0;
        millis   = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] wl[3];
        logic [31:0] ms;
        int          stp;
        logic        w;
        logic        r;
        logic [1:0]  a;
        logic [31:0] d;

        do_reset();
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_dout", bus.dout, 32'd0);

        // one-shot, then past compare with zero period
        tbl.push_back('{1'b1, 1'b0, 2'd1, 32'd5, 32'd0, 1'b0, 32'd0});
        tbl.push_back('{1'b1, 1'b0, 2'd0, 32'd1, 32'd1, 1'b0, 32'd0});
        tbl.push_back('{1'b0, 1'b0, 2'd0, 32'd0, 32'd2, 1'b0, 32'd0});
        tbl.push_back('{1'b0, 1'b0, 2'd0, 32'd0, 32'd3, 1'b0, 32'd0});
        tbl.push_back('{1'b0, 1'b0, 2'd0, 32'd0, 32'd4, 1'b0, 32'd0});
        tbl.push_back('{1'b0, 1'b0, 2'd0, 32'd0, 32'd5, 1'b1, 32'd0});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 32'd0, 32'd6, 1'b1, 32'd4});
        tbl.push_back('{1'b1, 1'b0, 2'd0, 32'd4, 32'd7, 1'b0, 32'd4});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 32'd0, 32'd8, 1'b0, 32'd0});
        tbl.push_back('{1'b0, 1'b0, 2'd0, 32'd0, 32'd12, 1'b0, 32'd0});
        tbl.push_back('{1'b0, 1'b0, 2'd0, 32'd0, 32'd20, 1'b0, 32'd0});
        tbl.push_back('{1'b1, 1'b0, 2'd1, 32'd10, 32'd50, 1'b0, 32'd0});
        tbl.push_back('{1'b1, 1'b0, 2'd2, 32'd0, 32'd50, 1'b0, 32'd0});
        tbl.push_back('{1'b1, 1'b0, 2'd0, 32'd3, 32'd50, 1'b0, 32'd0});
        tbl.push_back('{1'b0, 1'b0, 2'd0, 32'd0, 32'd50, 1'b1, 32'd0});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 32'd0, 32'd50, 1'b1, 32'd6});
        tbl.push_back('{1'b0, 1'b1, 2'd3, 32'd0, 32'd50, 1'b1, 32'd50});
        tbl.push_back('{1'b1, 1'b0, 2'd0, 32'd6, 32'd50, 1'b0, 32'd50});
        tbl.push_back('{1'b0, 1'b0, 2'd0, 32'd0, 32'd50, 1'b0, 32'd50});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 32'd0, 32'd50, 1'b0, 32'd2});
        foreach (tbl[i]) begin
            cyc(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].din, tbl[i].ms);
            check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, tbl[i].irq});
            check($sformatf("vec%0d_dout", i), bus.dout, tbl[i].dout);
        end

        // periodic: fires at 3, 7, 11 with software clearing each time
        do_reset();
        cyc(1'b1, 1'b0, 2'd2, 32'd4, 32'd0);
        cyc(1'b1, 1'b0, 2'd1, 32'd3, 32'd0);
        cyc(1'b1, 1'b0, 2'd0, 32'd3, 32'd0);
        for (int t = 1; t <= 12; t++) begin
            cyc(1'b0, 1'b0, 2'd0, 32'd0, 32'(t));
            if (t == 3 || t == 7 || t == 11) begin
                check($sformatf("per_fire_%0d", t), {31'd0, irq}, 32'd1);
                cyc(1'b1, 1'b0, 2'd0, 32'd7, 32'(t));
                check($sformatf("per_clr_%0d", t), {31'd0, irq}, 32'd0);
            end else begin
                check($sformatf("per_quiet_%0d", t), {31'd0, irq}, 32'd0);
            end
        end
        cyc(1'b0, 1'b1, 2'd1, 32'd0, 32'd12);
        check("per_cmp15", bus.dout, 32'd15);
        cyc(1'b0, 1'b1, 2'd0, 32'd0, 32'd12);
        check("per_ctrl", bus.dout, 32'd3);

        // wrap-around compare and reload across zero
        do_reset();
        cyc(1'b1, 1'b0, 2'd1, 32'd1, 32'hFFFF_FFFD);
        cyc(1'b1, 1'b0, 2'd0, 32'd1, 32'hFFFF_FFFD);
        wl = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
        foreach (wl[i]) begin
            cyc(1'b0, 1'b0, 2'd0, 32'd0, wl[i]);
            check($sformatf("wrap_quiet_%0d", i), {31'd0, irq}, 32'd0);
        end
        cyc(1'b0, 1'b0, 2'd0, 32'd0, 32'd1);
        check("wrap_fire", {31'd0, irq}, 32'd1);
        cyc(1'b1, 1'b0, 2'd2, 32'd2, 32'hFFFF_FFF0);
        cyc(1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF0);
        cyc(1'b1, 1'b0, 2'd0, 32'd7, 32'hFFFF_FFF0);
        check("wrap_armed", {31'd0, irq}, 32'd0);
        cyc(1'b0, 1'b0, 2'd0, 32'd0, 32'hFFFF_FFFF);
        check("wrap_fire2", {31'd0, irq}, 32'd1);
        cyc(1'b0, 1'b1, 2'd1, 32'd0, 32'hFFFF_FFFF);
        check("wrap_reload", bus.dout, 32'd1);

        // writes colliding with a fire
        do_reset();
        cyc(1'b1, 1'b0, 2'd1, 32'd10, 32'd0);
        cyc(1'b1, 1'b0, 2'd0, 32'd1, 32'd0);
        cyc(1'b0, 1'b0, 2'd0, 32'd0, 32'd5);
        check("sim_early", {31'd0, irq}, 32'd0);
        cyc(1'b1, 1'b0, 2'd0, 32'd4, 32'd10);
        check("sim_ctrl_irq", {31'd0, irq}, 32'd1);
        cyc(1'b0, 1'b1, 2'd0, 32'd0, 32'd11);
        check("sim_ctrl_rd", bus.dout, 32'd4);
        cyc(1'b1, 1'b0, 2'd1, 32'd20, 32'd11);
        cyc(1'b1, 1'b0, 2'd0, 32'd5, 32'd11);
        check("sim_rearm", {31'd0, irq}, 32'd0);
        cyc(1'b1, 1'b0, 2'd1, 32'd100, 32'd20);
        check("sim_cmp_irq", {31'd0, irq}, 32'd1);
        cyc(1'b0, 1'b1, 2'd1, 32'd0, 32'd21);
        check("sim_cmp_rd", bus.dout, 32'd100);
        cyc(1'b0, 1'b1, 2'd0, 32'd0, 32'd21);
        check("sim_ctrl2", bus.dout, 32'd4);

        // asynchronous reset between clock edges
        #2;
        reset = 1'b0;
        #1;
        check("arst_irq", {31'd0, irq}, 32'd0);
        check("arst_dout", bus.dout, 32'd0);
        model_clear();
        @(negedge clk);
        reset  = 1'b1;
        millis = '0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 2'(i), 32'd0, 32'd0);
            check($sformatf("arst_reg%0d", i), bus.dout, 32'd0);
        end

        // random traffic
        do_reset();
        ms = $urandom;
        for (int i = 0; i < 4000; i++) begin
            stp = $urandom_range(0, 15);
            if (stp < 12) ms = ms + 32'($urandom_range(0, 3));
            else if (stp < 15) ms = ms + 32'($urandom_range(0, 200));
            else ms = $urandom;
            w = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 1) == 1);
            a = 2'($urandom_range(0, 3));
            case (a)
                2'd0: d = ($urandom & 32'hFFFF_FFF8) | 32'($urandom_range(0, 7));
                2'd1: d = ms + 32'($urandom_range(0, 40)) - 32'd10;
                2'd2: d = 32'($urandom_range(0, 8));
                default: d = $urandom;
            endcase
            cyc(w, r, a, d, ms);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/module_millis_alarm.md
Name: module_millis_alarm

Overview:
Memory-mapped alarm/interrupt unit placed directly downstream of the millisecond timer. It consumes the free-running millisecond count and raises a level interrupt to the core when the count reaches a programmed compare value. It supports one-shot and periodic (auto-reload) modes and uses wrap-safe comparison. Software programs it over the simple peripheral bus: we/re, word address, data in and data out.

Parameters:
TIMER_WIDTH, 32, width of the millis input, CMP and PERIOD registers (2..32)
DATA_WIDTH, 32, bus data width (must be >= TIMER_WIDTH)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
millis  input  TIMER_WIDTH  current millisecond count from the timer stage
we  input  1  bus write strobe, one cycle per access
re  input  1  bus read strobe, one cycle per access
addr  input  2  word address: 0 CTRL, 1 CMP, 2 PERIOD, 3 MILLIS
din  input  DATA_WIDTH  bus write data
dout  output  DATA_WIDTH  bus read data, registered
irq  output  1  interrupt request, level, equals CTRL.PEND

Behaviour:
- Reset (reset=0, asynchronous): CTRL=0, CMP=0, PERIOD=0, dout=0, irq=0. Deassertion is sampled at the next rising edge; no fire is possible in the first cycle after release because EN=0.
- CTRL bits:
  - bit0 EN: read/write.
  - bit1 PERIODIC: read/write.
  - bit2 PEND: read; writing 1 clears it, writing 0 leaves it unchanged.
  - Other bits read 0 and ignore writes.
- CMP and PERIOD: read/write, lower TIMER_WIDTH bits. Upper bus bits are ignored on write and read 0.
- MILLIS: read-only live snapshot of the millis input. Writes to it are ignored.
- Reads: when re=1 at edge n, dout holds the addressed value from edge n (pre-write state if we=1 in the same cycle). dout holds its value until the next read. we and re together are legal.
- Fire condition, evaluated every cycle: EN=1 and the MSB of (millis - CMP) mod 2^TIMER_WIDTH is 0. This means millis is at or past CMP, wrap-safe within half range.
- On a fire at edge n:
  - PEND is set at edge n, so irq is high after edge n (latency 0 cycles from millis reaching CMP).
  - PERIODIC=1 and PERIOD!=0: CMP becomes CMP+PERIOD (mod 2^W) and EN stays 1.
  - PERIODIC=0, or PERIOD=0: EN is cleared (one-shot). A PERIOD of 0 never causes a refire every cycle.
- If millis lags more than one PERIOD (e.g. EN set late), successive cycles fire and advance CMP until it catches up. PEND simply stays set; no fire count is kept.
- Simultaneous events, same edge:
  - CMP write and fire: the fire is evaluated on the old CMP, and the written value wins for CMP.
  - CTRL write and fire: the written EN/PERIODIC values win, and PEND is still set by the fire (set beats clear).
  - PEND clear without a fire: PEND goes to 0 at that edge.
- Arming with CMP already in the past: fire at the first edge with EN=1.
- Reset mid-operation: all state returns to reset values immediately, irq drops asynchronously.
- All CMP/PERIOD arithmetic is unsigned modulo 2^TIMER_WIDTH, and the comparison uses no signed extension beyond the difference MSB.

Test Plan:
1. One-shot. Write CMP=5, CTRL=0x1, with millis counting from 0. Required: irq rises at the edge where millis=5; CTRL then reads 0x4 (EN=0, PEND=1). Writing CTRL=0x4 drops irq next edge and it stays low while millis runs on to 20.
2. Periodic. CMP=3, PERIOD=4, CTRL=0x3. Required: fires at millis 3, 7, 11. PEND is cleared by software after each fire; CMP reads 15 after the third fire; EN stays 1.
3. Wrap-around. With TIMER_WIDTH=32: millis=0xFFFFFFFE, CMP=0x00000001, EN=1. Required: no fire at 0xFFFFFFFE, 0xFFFFFFFF or 0x0; fire when millis=0x1. CMP=0xFFFFFFFF with PERIOD=2 reloads to 0x1.
4. Simultaneous events. On the fire edge, write CTRL=0x4 (clear PEND, EN=0). Required: PEND=1 and EN=0 after that edge, irq high. On the fire edge, write CMP=100: CMP reads 100 and PEND=1.
5. Past compare and zero period. With millis=50, write CMP=10, then CTRL=0x3 with PERIOD=0. Required: fire on the first EN edge, EN cleared, single fire only. Reading MILLIS returns 50 (registered read, one cycle after re).
6. Async reset. Assert reset low mid-period with irq=1 and no clock edge. Required: irq=0 and dout=0 immediately; all registers read 0 after release.
